// File: rtl/controle_polinomio_if.sv
// Handshake and datapath-control bundle between the polynomial sequencer and its neighbours.
// master: requester/datapath side; slave: the controle_polinomio sequencer.
interface controle_polinomio_if;
  logic       start;
  logic       modo;
  logic       lx;
  logic [1:0] m0;
  logic [1:0] m1;
  logic [1:0] m2;
  logic       h;
  logic       ls;
  logic       lh;
  logic       done;
  logic       busy;

  modport master (
    output start, modo,
    input  lx, m0, m1, m2, h, ls, lh, done, busy
  );

  modport slave (
    input  start, modo,
    output lx, m0, m1, m2, h, ls, lh, done, busy
  );
endinterface

// File: rtl/controle_polinomio.sv
// Moore sequencer driving a 16-bit datapath through Horner evaluation of A*X^2+B*X+C or A*X+B.
// Optional macro DONE_HOLD_EN: DONE is held until start is sampled low.
module controle_polinomio #(
  parameter int unsigned MUL_WAIT = 0
) (
  input logic                 ck,
  input logic                 rst,
  controle_polinomio_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StMul1 = 3'd2,
    StAdd1 = 3'd3,
    StMul2 = 3'd4,
    StAdd2 = 3'd5,
    StDone = 3'd6
  } state_e;

  localparam logic [3:0] WaitMax = 4'(MUL_WAIT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       modo_q, modo_d;

  logic       lx_q, lx_d;
  logic [1:0] m0_q, m0_d;
  logic [1:0] m1_q, m1_d;
  logic [1:0] m2_q, m2_d;
  logic       h_q, h_d;
  logic       ls_q, ls_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d = StIdle;
    cnt_d   = cnt_q;
    modo_d  = modo_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          modo_d  = bus.modo;
          state_d = StLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StMul1;
      end
      StMul1: begin
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == WaitMax) ? StAdd1 : StMul1;
      end
      StAdd1: begin
        cnt_d   = '0;
        state_d = modo_q ? StDone : StMul2;
      end
      StMul2: begin
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == WaitMax) ? StAdd2 : StMul2;
      end
      StAdd2: state_d = StDone;
      StDone: begin
`ifdef DONE_HOLD_EN
        state_d = bus.start ? StDone : StIdle;
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they always match the state reg.
  always_comb begin
    lx_d   = 1'b0;
    m0_d   = 2'b00;
    m1_d   = 2'b00;
    m2_d   = 2'b00;
    h_d    = 1'b0;
    ls_d   = 1'b0;
    done_d = 1'b0;
    busy_d = 1'b0;
    case (state_d)
      StLoad: begin
        lx_d   = 1'b1;
        busy_d = 1'b1;
      end
      StMul1: begin
        m0_d   = 2'b01;
        h_d    = 1'b1;
        ls_d   = (cnt_d == WaitMax);
        busy_d = 1'b1;
      end
      StAdd1: begin
        m0_d   = 2'b10;
        m1_d   = 2'b10;
        m2_d   = 2'b01;
        ls_d   = 1'b1;
        busy_d = 1'b1;
      end
      StMul2: begin
        m1_d   = 2'b10;
        h_d    = 1'b1;
        ls_d   = (cnt_d == WaitMax);
        busy_d = 1'b1;
      end
      StAdd2: begin
        m0_d   = 2'b11;
        m1_d   = 2'b10;
        m2_d   = 2'b01;
        ls_d   = 1'b1;
        busy_d = 1'b1;
      end
      StDone:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      modo_q  <= 1'b0;
      lx_q    <= 1'b0;
      m0_q    <= 2'b00;
      m1_q    <= 2'b00;
      m2_q    <= 2'b00;
      h_q     <= 1'b0;
      ls_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      modo_q  <= modo_d;
      lx_q    <= lx_d;
      m0_q    <= m0_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      h_q     <= h_d;
      ls_q    <= ls_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.lx   = lx_q;
  assign bus.m0   = m0_q;
  assign bus.m1   = m1_q;
  assign bus.m2   = m2_q;
  assign bus.h    = h_q;
  assign bus.ls   = ls_q;
  assign bus.lh   = 1'b0;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_controle_polinomio.sv
// Bench for controle_polinomio: two instances (MUL_WAIT 0 and 2) in closed loop with a datapath
// model; per-cycle control vectors and final results are checked against a reference model.
module tb_controle_polinomio;

  typedef logic [11:0] vec_t;  // {lx, m0, m1, m2, h, ls, lh, done, busy}
  typedef vec_t vec_q_t[$];

  logic        ck = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        modo = 1'b0;
  logic [15:0] op_x = '0, op_a = '0, op_b = '0, op_c = '0;
  int          checks = 0;
  int          errors = 0;

  controle_polinomio_if bus0 ();
  controle_polinomio_if bus2 ();

  assign bus0.start = start;
  assign bus0.modo  = modo;
  assign bus2.start = start;
  assign bus2.modo  = modo;

  controle_polinomio #(.MUL_WAIT(0)) dut0 (.ck(ck), .rst(rst), .bus(bus0.slave));
  controle_polinomio #(.MUL_WAIT(2)) dut2 (.ck(ck), .rst(rst), .bus(bus2.slave));

  always #5 ck = ~ck;

  vec_t obs0, obs2;
  assign obs0 = {bus0.lx, bus0.m0, bus0.m1, bus0.m2, bus0.h, bus0.ls, bus0.lh, bus0.done, bus0.busy};
  assign obs2 = {bus2.lx, bus2.m0, bus2.m1, bus2.m2, bus2.h, bus2.ls, bus2.lh, bus2.done, bus2.busy};

  // Datapath model: Reg_X, Reg_S, Reg_H with the documented mux and ALU semantics.
  function automatic logic [15:0] alu(input logic [1:0] s0, input logic [1:0] s1,
                                      input logic [1:0] s2, input logic hm,
                                      input logic [15:0] rx, input logic [15:0] rs,
                                      input logic [15:0] rh);
    logic [15:0] p, i1, i2, r;
    case (s0)
      2'b00:   p = 16'd0;
      2'b01:   p = op_a;
      2'b10:   p = op_b;
      default: p = op_c;
    endcase
    case (s1)
      2'b00:   i1 = p;
      2'b01:   i1 = rx;
      2'b10:   i1 = rs;
      default: i1 = rh;
    endcase
    case (s2)
      2'b00:   i2 = rx;
      2'b01:   i2 = p;
      2'b10:   i2 = rs;
      default: i2 = rh;
    endcase
    if (hm) r = i1 * i2;
    else    r = i1 + i2;
    return r;
  endfunction

  logic [15:0] rx0, rs0, rh0, rx2, rs2, rh2;

  always @(posedge ck or negedge rst) begin
    if (!rst) begin
      rx0 <= '0; rs0 <= '0; rh0 <= '0;
    end else begin
      if (bus0.lx) rx0 <= op_x;
      if (bus0.ls) rs0 <= alu(bus0.m0, bus0.m1, bus0.m2, bus0.h, rx0, rs0, rh0);
      if (bus0.lh) rh0 <= alu(bus0.m0, bus0.m1, bus0.m2, bus0.h, rx0, rs0, rh0);
    end
  end

  always @(posedge ck or negedge rst) begin
    if (!rst) begin
      rx2 <= '0; rs2 <= '0; rh2 <= '0;
    end else begin
      if (bus2.lx) rx2 <= op_x;
      if (bus2.ls) rs2 <= alu(bus2.m0, bus2.m1, bus2.m2, bus2.h, rx2, rs2, rh2);
      if (bus2.lh) rh2 <= alu(bus2.m0, bus2.m1, bus2.m2, bus2.h, rx2, rs2, rh2);
    end
  end

  function automatic vec_t mk(input logic lx, input logic [1:0] s0, input logic [1:0] s1,
                              input logic [1:0] s2, input logic hm, input logic l,
                              input logic d, input logic b);
    return {lx, s0, s1, s2, hm, l, 1'b0, d, b};
  endfunction

  // Expected control vectors of one evaluation, from LOAD through DONE.
  function automatic vec_q_t trace(input int w, input bit md);
    vec_q_t q;
    q = {};
    q.push_back(mk(1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int k = 0; k <= w; k++) q.push_back(mk(1'b0, 2'd1, 2'd0, 2'd0, 1'b1, k == w, 1'b0, 1'b1));
    q.push_back(mk(1'b0, 2'd2, 2'd2, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1));
    if (!md) begin
      for (int k = 0; k <= w; k++) q.push_back(mk(1'b0, 2'd0, 2'd2, 2'd0, 1'b1, k == w, 1'b0, 1'b1));
      q.push_back(mk(1'b0, 2'd3, 2'd2, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1));
    end
    q.push_back(mk(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    return q;
  endfunction

  // Expected vectors for n cycles after the start edge, optionally with start held high.
  function automatic vec_q_t sched(input int w, input bit m1st, input bit m2nd, input bit hold,
                                   input int n);
    vec_q_t q, t;
    q = trace(w, m1st);
    t = trace(w, m2nd);
    if (!hold) begin
      while (q.size() < n) q.push_back('0);
    end else begin
`ifdef DONE_HOLD_EN
      while (q.size() < n) q.push_back(mk(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
`else
      while (q.size() < n) begin
        q.push_back('0);
        foreach (t[j]) q.push_back(t[j]);
      end
`endif
    end
    return q;
  endfunction

  function automatic logic [15:0] poly(input bit md, input logic [15:0] x, input logic [15:0] a,
                                       input logic [15:0] b, input logic [15:0] c);
    logic [15:0] r;
    if (md) r = a * x + b;
    else    r = a * x * x + b * x + c;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: start one evaluation and check every following cycle.
  task automatic run_op(input bit md, input logic [15:0] x, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] c, input bit tog, input int hold);
    vec_q_t e0, e2, t;
    int n, d0, d2;
    logic [15:0] want;
    op_x = x; op_a = a; op_b = b; op_c = c;
    modo  = md;
    start = 1'b1;
    t  = trace(0, md);
    d0 = t.size();
    t  = trace(2, md);
    d2 = t.size();
    n  = (hold > 0) ? hold : d2 + 2;
    e0 = sched(0, md, md ^ tog, hold > 0, n);
    e2 = sched(2, md, md ^ tog, hold > 0, n);
    want = poly(md, x, a, b, c);
    for (int i = 1; i <= n; i++) begin
      @(negedge ck);
      chk($sformatf("w0 md%0d cyc%0d", md, i), 32'(obs0), 32'(e0[i-1]));
      chk($sformatf("w2 md%0d cyc%0d", md, i), 32'(obs2), 32'(e2[i-1]));
      if (i == d0) chk($sformatf("w0 result md%0d", md), 32'(rs0), 32'(want));
      if (i == d2) chk($sformatf("w2 result md%0d", md), 32'(rs2), 32'(want));
      if (hold == 0 && i == 1) start = 1'b0;
      if (tog && i == 2) modo = ~modo;
      if (hold > 0 && i == hold) start = 1'b0;
    end
  endtask

  // Called at a negedge: assert reset mid-cycle, check outputs drop at once, then recover idle.
  task automatic reset_mid(input string tag);
    #2;
    rst = 1'b0;
    #1;
    chk({tag, " w0 immediate"}, 32'(obs0), 32'd0);
    chk({tag, " w2 immediate"}, 32'(obs2), 32'd0);
    repeat (2) @(negedge ck);
    start = 1'b0;
    rst   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ck);
      chk({tag, " w0 idle"}, 32'(obs0), 32'd0);
      chk({tag, " w2 idle"}, 32'(obs2), 32'd0);
    end
  endtask

  initial begin
    repeat (2) @(negedge ck);
    chk("reset w0", 32'(obs0), 32'd0);
    chk("reset w2", 32'(obs2), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge ck);
    chk("idle w0", 32'(obs0), 32'd0);
    chk("idle w2", 32'(obs2), 32'd0);

    run_op(1'b0, 16'd3, 16'd2, 16'd5, 16'd7, 1'b0, 0);
    run_op(1'b1, 16'd4, 16'd3, 16'd1, 16'd0, 1'b0, 0);

    // Reset with start held high, during an evaluation.
    op_x = 16'd3; op_a = 16'd2; op_b = 16'd5; op_c = 16'd7;
    modo  = 1'b0;
    start = 1'b1;
    @(negedge ck);
    chk("load before reset", 32'(obs0[11]), 32'd1);
    reset_mid("reset start high");

    // Start held through the run with modo toggled during MUL1.
    run_op(1'b0, 16'd3, 16'd2, 16'd5, 16'd7, 1'b1, 16);
    reset_mid("after hold");

    // Abort during ADD1 of the zero-wait instance, then a fresh evaluation.
    op_x = 16'd3; op_a = 16'd2; op_b = 16'd5; op_c = 16'd7;
    modo  = 1'b0;
    start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    repeat (2) @(negedge ck);
    chk("in add1 w0", 32'(obs0), 32'(mk(1'b0, 2'd2, 2'd2, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1)));
    reset_mid("abort");
    run_op(1'b0, 16'd0, 16'd9, 16'd9, 16'd5, 1'b0, 0);

    for (int r = 0; r < 8; r++) begin
      run_op(1'($urandom_range(1, 0)), 16'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom), 1'($urandom_range(1, 0)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
